util_trafic_checker_mc: RTL

//  Multi-channel AXI4-Stream traffic sink/checker; next generation of the traffic receiver.

---
 rtl/util_trafic_pkg.sv | 31 +++
 rtl/util_trafic_if.sv | 25 ++
 rtl/util_trafic_rate_limiter.sv | 40 ++++
 rtl/util_trafic_checker_mc.sv | 111 +++++++++++
 4 files changed

// File: rtl/util_trafic_pkg.sv
// Shared definitions for the traffic checker and its rate limiter.
// Error bit positions, credit sizing helpers.
package util_trafic_pkg;

  localparam int ERR_DATA = 0;
  localparam int ERR_LAST = 1;
  localparam int ERR_KEEP = 2;
  localparam int ERR_TID  = 3;
  localparam int ERR_W    = 4;

  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int credit_w(
    input longint clk_freq,
    input longint speed,
    input longint tbyte
  );
    return clog2(2 * tbyte * clk_freq + speed) + 1;
  endfunction

endpackage

// File: rtl/util_trafic_if.sv
// AXI4-Stream bundle with source and sink views.
// Source drives payload, sink drives tready.
interface util_trafic_if #(
  parameter int TBYTE_NUM  = 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TBYTE_NUM*8-1:0] tdata;
  logic [TBYTE_NUM-1:0]   tkeep;
  logic                   tlast;
  logic [ID_WIDTH-1:0]    tid;
  logic [DEST_WIDTH-1:0]  tdest;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tid, tdest,
    output tready
  );
endinterface

// File: rtl/util_trafic_rate_limiter.sv
// Byte-rate credit bucket: grant when one beat worth of credit is banked.
// Bucket caps at two beats, so bursts never exceed two back-to-back grants.
module util_trafic_rate_limiter
  import util_trafic_pkg::*;
#(
  parameter longint CLK_FREQ  = 100_000_000,
  parameter longint SPEED     = 2_500_000,
  parameter int     TBYTE_NUM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic take,
  output logic grant
);

  localparam longint TH = longint'(TBYTE_NUM) * CLK_FREQ;
  localparam int     AW = credit_w(CLK_FREQ, SPEED, longint'(TBYTE_NUM));

  localparam logic [AW-1:0] TH_V  = AW'(TH);
  localparam logic [AW-1:0] CAP_V = AW'(2 * TH);
  localparam logic [AW-1:0] SPD_V = AW'(SPEED);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc + SPD_V;
    if (take && acc_nxt >= TH_V) acc_nxt = acc_nxt - TH_V;
    if (acc_nxt > CAP_V) acc_nxt = CAP_V;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= acc_nxt;
  end

  assign grant = en & ~rst & ((SPEED == 0) | (acc >= TH_V));

endmodule

// File: rtl/util_trafic_checker_mc.sv
// Multi-channel AXI4-Stream sink: throttled tready, per-tdest sequence,
// packet length, tkeep and tid checks, sticky error and saturating counters.
module util_trafic_checker_mc
  import util_trafic_pkg::*;
#(
  parameter longint CLK_FREQ   = 100_000_000,
  parameter longint SPEED      = 2_500_000,
  parameter int     TBYTE_NUM  = 8,
  parameter int     ID_WIDTH   = 1,
  parameter int     DEST_WIDTH = 2,
  parameter int     PKT_LEN    = 16,
  parameter int     CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  util_trafic_if.slave          s_axis,
  output logic                  error,
  output logic [ERR_W-1:0]      err_code,
  output logic [DEST_WIDTH-1:0] err_dest,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int DW  = TBYTE_NUM * 8;
  localparam int NCH = 1 << DEST_WIDTH;
  localparam int BW  = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

  logic [DW-1:0]       seq   [NCH];
  logic [BW-1:0]       bidx  [NCH];
  logic [ID_WIDTH-1:0] tid_l [NCH];
  logic [NCH-1:0]      sync;

  logic                  hs;
  logic                  at_end;
  logic [DEST_WIDTH-1:0] d;
  logic [ERR_W-1:0]      errs;

  util_trafic_rate_limiter #(
    .CLK_FREQ  (CLK_FREQ),
    .SPEED     (SPEED),
    .TBYTE_NUM (TBYTE_NUM)
  ) u_rate (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .take  (hs),
    .grant (s_axis.tready)
  );

  assign hs = s_axis.tvalid & s_axis.tready;
  assign d  = s_axis.tdest;

  always_comb begin
    at_end         = (bidx[d] == LAST_IDX);
    errs           = '0;
    errs[ERR_DATA] = sync[d] & (s_axis.tdata != seq[d]);
    errs[ERR_LAST] = s_axis.tlast != at_end;
    errs[ERR_KEEP] = s_axis.tkeep != '1;
    errs[ERR_TID]  = (bidx[d] != '0) & (s_axis.tid != tid_l[d]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        seq[i]   <= '0;
        bidx[i]  <= '0;
        tid_l[i] <= '0;
      end
      sync     <= '0;
      error    <= 1'b0;
      err_code <= '0;
      err_dest <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      // Channel tracking follows every beat, even one swallowed by clr.
      if (hs) begin
        seq[d]  <= s_axis.tdata + DW'(1);
        bidx[d] <= (s_axis.tlast | at_end) ? '0 : bidx[d] + BW'(1);
        if (bidx[d] == '0) tid_l[d] <= s_axis.tid;
        sync[d] <= 1'b1;
      end
      if (clr) begin
        sync     <= '0;
        error    <= 1'b0;
        err_code <= '0;
        err_dest <= '0;
        beat_cnt <= '0;
        pkt_cnt  <= '0;
        err_cnt  <= '0;
      end else if (hs) begin
        if (~&beat_cnt) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        if (s_axis.tlast && ~&pkt_cnt) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
        if (|errs) begin
          if (~&err_cnt) err_cnt <= err_cnt + CNT_WIDTH'(1);
          error <= 1'b1;
          if (!error) begin
            err_code <= errs;
            err_dest <= d;
          end
        end
      end
    end
  end

endmodule
